multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle variant of the CPU datapath: register file, ALU, immediate extender and unified instruction/data memory.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps. Drives every datapath mux/enable, including the immediate extender's zero_ext select.
- Stalls on a memory ready handshake.
- Sits between the instruction register (opcode field) and the datapath.

Parameters:
- OPW, 6, opcode width.
- STW, 4, state register width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  OPW  IR[31:26]; sampled only in DECODE.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if branch condition true.
- branch_ne  out  1  1 = condition is !zero (bne); 0 = zero (beq).
- pc_src  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load IR and MDR from memory data.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = extended imm, 11 = extended imm << 2.
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded, 11 opcode-decoded immediate op.
- zero_ext  out  1  to immediate extender: 1 = zero extend, 0 = sign extend.
- illegal  out  1  one-cycle pulse on unknown opcode.
- state  out  STW  current state, for debug.

Behaviour:
- States and encoding:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, I_WB=11, TRAP=12.
  - Codes 13–15 go to FETCH on the next edge, with all outputs 0.
- reset high at an edge:
  - state <= FETCH, op_q <= 0.
  - While reset is high, all outputs are forced 0 and state reads 0.
  - Reset mid-instruction abandons it with no further writes.
- Outputs are Moore, decoded from the registered state (and op_q where noted). Any signal not listed for a state is 0.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write are asserted only while mem_ready=1, which is the exception to pure Moore.
  - Go to DECODE when mem_ready=1; otherwise hold with no PC/IR change.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - zero_ext=0. Latch op_q <= opcode.
  - Next state by opcode: 0x00 → EXEC_R; 0x23, 0x2B → MEM_ADDR; 0x04, 0x05 → BRANCH; 0x02 → JUMP; 0x08, 0x0A, 0x0C, 0x0D → EXEC_I; any other → TRAP.
- MEM_ADDR:
  - alu_src_a=1, alu_src_b=10, alu_op=00, zero_ext=0.
  - Next state: lw → MEM_RD, sw → MEM_WR.
- MEM_RD:
  - mem_read=1, i_or_d=1.
  - Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Go to FETCH.
- MEM_WR:
  - mem_write=1, i_or_d=1.
  - Hold until mem_ready, then go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Go to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01.
  - branch_ne = (op_q==0x05). Go to FETCH.
- JUMP: pc_write=1, pc_src=10. Go to FETCH.
- EXEC_I:
  - alu_src_a=1, alu_src_b=10, alu_op=11.
  - zero_ext = 1 for op_q 0x0C (andi) or 0x0D (ori); 0 for 0x08 and 0x0A.
  - Go to I_WB.
- I_WB:
  - reg_write=1, reg_dst=0, mem_to_reg=0.
  - zero_ext is held at the EXEC_I value. Go to FETCH.
- TRAP: illegal=1 for exactly one cycle, no writes. Go to FETCH; the PC was already advanced, so the instruction is skipped.
- Cycle counts with mem_ready tied to 1:
  - lw 5; R-type, sw and imm 4; beq, bne and j 3; illegal 3.
  - Each wait cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds 1.
- opcode changes outside DECODE must have no effect, because op_q is used.
- mem_read and mem_write are never both 1. reg_write and any PC write are never both 1 in the same cycle.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 and opcode=0x00 → all outputs 0 during reset; then state sequence 0,1,6,7,0, with reg_write=1 and reg_dst=1 only in state 7.
- lw (0x23) with mem_ready low for 2 cycles in FETCH and 1 cycle in MEM_RD → sequence 0,0,0,1,2,3,3,4,0; ir_write only on the third FETCH cycle; mem_to_reg=1 in state 4.
- ori (0x0D), opcode driven to 0x08 after DECODE → zero_ext=1 in states 10 and 11; alu_op=11 in state 10. Repeat with addi → zero_ext=0.
- bne (0x05) → state 8 with pc_write_cond=1, branch_ne=1, pc_src=01. beq (0x04) → branch_ne=0. Three cycles each.
- Opcode 0x3F → sequence 0,1,12,0; illegal=1 exactly in state 12; no reg_write, mem_write or pc_write there.
- sw (0x2B) with reset asserted during MEM_WR while mem_ready=0 → mem_write drops in the reset cycle; FETCH follows reset release; no write completes.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle datapath. Walks each instruction
// through fetch, decode, execute, memory and writeback steps and drives
// every datapath mux/enable from the registered state (Moore), except
// ir_write/pc_write in FETCH which follow mem_ready.
//
// Memory handshake: the controller holds mem_read or mem_write (with
// i_or_d) steady in FETCH, MEM_RD and MEM_WR until mem_ready is seen high
// on a rising edge; that edge is the one on which the access completes and
// the FSM advances. mem_ready low simply stretches the state by a cycle.
module multicycle_control #(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           pc_write,
    output logic           pc_write_cond,
    output logic           branch_ne,
    output logic [1:0]     pc_src,
    output logic           i_or_d,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic           zero_ext,
    output logic           illegal,
    output logic [STW-1:0] state
);

    typedef enum logic [STW-1:0] {
        S_FETCH    = STW'(0),
        S_DECODE   = STW'(1),
        S_MEM_ADDR = STW'(2),
        S_MEM_RD   = STW'(3),
        S_MEM_WB   = STW'(4),
        S_MEM_WR   = STW'(5),
        S_EXEC_R   = STW'(6),
        S_R_WB     = STW'(7),
        S_BRANCH   = STW'(8),
        S_JUMP     = STW'(9),
        S_EXEC_I   = STW'(10),
        S_I_WB     = STW'(11),
        S_TRAP     = STW'(12)
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'('h00);
    localparam logic [OPW-1:0] OP_J     = OPW'('h02);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'('h04);
    localparam logic [OPW-1:0] OP_BNE   = OPW'('h05);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'('h08);
    localparam logic [OPW-1:0] OP_SLTI  = OPW'('h0A);
    localparam logic [OPW-1:0] OP_ANDI  = OPW'('h0C);
    localparam logic [OPW-1:0] OP_ORI   = OPW'('h0D);
    localparam logic [OPW-1:0] OP_LW    = OPW'('h23);
    localparam logic [OPW-1:0] OP_SW    = OPW'('h2B);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic           logical_imm;

    // State and latched opcode registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // andi/ori zero-extend their immediate; addi/slti sign-extend
    assign logical_imm = (op_q == OP_ANDI) || (op_q == OP_ORI);

    // Debug view of the state; reads FETCH while reset is held
    assign state = reset ? '0 : state_q;

    // Next-state logic and opcode capture in DECODE
    always_comb begin
        state_d = S_FETCH;
        op_d    = op_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_RTYPE:                           state_d = S_EXEC_R;
                    OP_LW, OP_SW:                       state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
                    OP_J:                               state_d = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  state_d = S_EXEC_I;
                    default:                            state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   state_d = S_R_WB;
            S_EXEC_I:   state_d = S_I_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Datapath control decode; everything is zero during reset
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_src        = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        zero_ext      = 1'b0;
        illegal       = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_src        = 2'b01;
                    branch_ne     = (op_q == OP_BNE);
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b11;
                    zero_ext  = logical_imm;
                end
                S_I_WB: begin
                    reg_write = 1'b1;
                    zero_ext  = logical_imm;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a driver issues one directed input vector
// per cycle and queues the hand-derived expected output word; a monitor
// pops and compares on every falling edge.
module tb_multicycle_control;
  localparam int W = 23;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
  logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, zero_ext, illegal;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;

  // Expected output words, one per distinct state/condition
  logic [W-1:0] e_zero, e_fetch, e_fetch_wait, e_decode, e_mem_addr, e_mem_rd, e_mem_wb;
  logic [W-1:0] e_mem_wr, e_exec_r, e_r_wb, e_br_ne, e_br_eq, e_jump;
  logic [W-1:0] e_exec_i_zx, e_exec_i_sx, e_i_wb_zx, e_i_wb_sx, e_trap;

  // clock / reset block
  always #5 clk = ~clk;

  multicycle_control #(.OPW(6), .STW(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .zero_ext(zero_ext), .illegal(illegal), .state(state)
  );

  function automatic logic [W-1:0] mk(
    input logic pw, input logic pwc, input logic bne, input logic [1:0] pcs,
    input logic iord, input logic mr, input logic mw, input logic irw,
    input logic rdst, input logic m2r, input logic rw, input logic asa,
    input logic [1:0] asb, input logic [1:0] aop, input logic zx,
    input logic ill, input logic [3:0] st);
    return {pw, pwc, bne, pcs, iord, mr, mw, irw, rdst, m2r, rw, asa, asb, aop, zx, ill, st};
  endfunction

  // driver: apply one cycle of inputs and queue what the DUT must show
  task automatic cyc(input logic rst, input logic rdy, input logic [5:0] op,
                     input logic [W-1:0] exp, input string tag);
    @(posedge clk);
    #1;
    reset = rst;
    mem_ready = rdy;
    opcode = op;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  function automatic logic [5:0] junk_op();
    return 6'($urandom_range(0, 63));
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] act, exp;
    string tag;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      act = {pc_write, pc_write_cond, branch_ne, pc_src, i_or_d, mem_read, mem_write,
             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
             zero_ext, illegal, state};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s got=%06h expected=%06h (state got %0d expected %0d)",
                 tag, act, exp, act[3:0], exp[3:0]);
      end
    end
  end

  initial begin
    //                pw pwc bne pcs   io mr mw irw rd m2r rw asa asb   aop   zx il st
    e_zero       = mk(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 4'd0);
    e_fetch      = mk(1, 0, 0, 2'd0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd1, 2'd0, 0, 0, 4'd0);
    e_fetch_wait = mk(0, 0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 0, 0, 4'd0);
    e_decode     = mk(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 0, 0, 4'd1);
    e_mem_addr   = mk(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0, 0, 4'd2);
    e_mem_rd     = mk(0, 0, 0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 4'd3);
    e_mem_wb     = mk(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 0, 0, 4'd4);
    e_mem_wr     = mk(0, 0, 0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 4'd5);
    e_exec_r     = mk(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 0, 0, 4'd6);
    e_r_wb       = mk(0, 0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 0, 0, 4'd7);
    e_br_ne      = mk(0, 1, 1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 0, 0, 4'd8);
    e_br_eq      = mk(0, 1, 0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 0, 0, 4'd8);
    e_jump       = mk(1, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 4'd9);
    e_exec_i_zx  = mk(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd3, 1, 0, 4'd10);
    e_exec_i_sx  = mk(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd3, 0, 0, 4'd10);
    e_i_wb_zx    = mk(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 1, 0, 4'd11);
    e_i_wb_sx    = mk(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 0, 0, 4'd11);
    e_trap       = mk(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 4'd12);

    // reset held two cycles, then an R-type instruction
    cyc(1, 1, 6'h00, e_zero, "reset_0");
    cyc(1, 1, 6'h00, e_zero, "reset_1");
    cyc(0, 1, 6'h00, e_fetch, "r_fetch");
    cyc(0, 1, 6'h00, e_decode, "r_decode");
    cyc(0, 1, junk_op(), e_exec_r, "r_exec");
    cyc(0, 1, junk_op(), e_r_wb, "r_wb");

    // lw with two fetch waits and one memory wait
    cyc(0, 0, junk_op(), e_fetch_wait, "lw_fetch_wait0");
    cyc(0, 0, junk_op(), e_fetch_wait, "lw_fetch_wait1");
    cyc(0, 1, junk_op(), e_fetch, "lw_fetch");
    cyc(0, 1, 6'h23, e_decode, "lw_decode");
    cyc(0, 1, 6'h2B, e_mem_addr, "lw_mem_addr");
    cyc(0, 0, 6'h2B, e_mem_rd, "lw_mem_rd_wait");
    cyc(0, 1, junk_op(), e_mem_rd, "lw_mem_rd");
    cyc(0, 1, junk_op(), e_mem_wb, "lw_mem_wb");

    // ori with the opcode changed after decode, then addi
    cyc(0, 1, junk_op(), e_fetch, "ori_fetch");
    cyc(0, 1, 6'h0D, e_decode, "ori_decode");
    cyc(0, 1, 6'h08, e_exec_i_zx, "ori_exec");
    cyc(0, 1, 6'h08, e_i_wb_zx, "ori_wb");
    cyc(0, 1, junk_op(), e_fetch, "addi_fetch");
    cyc(0, 1, 6'h08, e_decode, "addi_decode");
    cyc(0, 1, 6'h0D, e_exec_i_sx, "addi_exec");
    cyc(0, 1, 6'h0C, e_i_wb_sx, "addi_wb");

    // andi and slti extension select
    cyc(0, 1, junk_op(), e_fetch, "andi_fetch");
    cyc(0, 1, 6'h0C, e_decode, "andi_decode");
    cyc(0, 1, 6'h0A, e_exec_i_zx, "andi_exec");
    cyc(0, 1, 6'h0A, e_i_wb_zx, "andi_wb");
    cyc(0, 1, junk_op(), e_fetch, "slti_fetch");
    cyc(0, 1, 6'h0A, e_decode, "slti_decode");
    cyc(0, 1, 6'h0D, e_exec_i_sx, "slti_exec");
    cyc(0, 1, 6'h0D, e_i_wb_sx, "slti_wb");

    // bne, beq and j, three cycles each
    cyc(0, 1, junk_op(), e_fetch, "bne_fetch");
    cyc(0, 1, 6'h05, e_decode, "bne_decode");
    cyc(0, 1, 6'h04, e_br_ne, "bne_branch");
    cyc(0, 1, junk_op(), e_fetch, "beq_fetch");
    cyc(0, 1, 6'h04, e_decode, "beq_decode");
    cyc(0, 1, 6'h05, e_br_eq, "beq_branch");
    cyc(0, 1, junk_op(), e_fetch, "j_fetch");
    cyc(0, 1, 6'h02, e_decode, "j_decode");
    cyc(0, 1, junk_op(), e_jump, "j_jump");

    // illegal opcode
    cyc(0, 1, junk_op(), e_fetch, "ill_fetch");
    cyc(0, 1, 6'h3F, e_decode, "ill_decode");
    cyc(0, 1, 6'h00, e_trap, "ill_trap");

    // sw completing normally
    cyc(0, 1, junk_op(), e_fetch, "sw_fetch");
    cyc(0, 1, 6'h2B, e_decode, "sw_decode");
    cyc(0, 1, 6'h23, e_mem_addr, "sw_mem_addr");
    cyc(0, 1, 6'h23, e_mem_wr, "sw_mem_wr");

    // sw abandoned by reset while waiting on memory
    cyc(0, 1, junk_op(), e_fetch, "swr_fetch");
    cyc(0, 1, 6'h2B, e_decode, "swr_decode");
    cyc(0, 1, junk_op(), e_mem_addr, "swr_mem_addr");
    cyc(0, 0, junk_op(), e_mem_wr, "swr_mem_wr_wait");
    cyc(1, 0, junk_op(), e_zero, "swr_reset");
    cyc(0, 0, junk_op(), e_fetch_wait, "swr_after_reset");
    cyc(0, 1, junk_op(), e_fetch, "swr_refetch");

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending expected=0 pending", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
